// File: rtl/sdram_pkg.sv
// Shared types and constants for the SDRAM request front end.
package sdram_pkg;

  localparam int ADDR_W = 25;
  localparam int DATA_W = 32;

  // Burst-length codes carried untouched from requestor to controller.
  localparam logic [1:0] OPLEN_1 = 2'd0;
  localparam logic [1:0] OPLEN_2 = 2'd1;
  localparam logic [1:0] OPLEN_4 = 2'd2;
  localparam logic [1:0] OPLEN_8 = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP,
    ST_REF,
    ST_WAIT_REF
  } arb_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [1:0]        oplen;
    logic [DATA_W-1:0] wdata;
    logic              rw;
  } sdram_req_t;

endpackage

// File: rtl/sdram_refresh_timer.sv
// Auto-refresh interval counter: raises pending every REFRESH_INTERVAL cycles
// and flags a sticky overrun if the previous refresh was never taken.
module sdram_refresh_timer #(
  parameter int REFRESH_INTERVAL = 780
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ack,
  output logic pending,
  output logic overrun
);

  localparam int CNT_W = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(REFRESH_INTERVAL - 1);

  logic [CNT_W-1:0] cnt;
  logic             expire;

  assign expire = (cnt == '0);

  // A new expiry on the same cycle as an ack keeps pending set for the next refresh.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= RELOAD;
      pending <= 1'b0;
      overrun <= 1'b0;
    end else begin
      cnt <= expire ? RELOAD : cnt - 1'b1;
      if (expire)
        pending <= 1'b1;
      else if (ack)
        pending <= 1'b0;
      if (expire && pending && !ack)
        overrun <= 1'b1;
    end
  end

endmodule

// File: rtl/sdram_req_arbiter.sv
// Two-port request front end for the SDRAM controller: 1-entry slot per port,
// round-robin grant, refresh injection at top priority, response routing.
module sdram_req_arbiter
  import sdram_pkg::*;
#(
  parameter int REFRESH_INTERVAL = 780
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [1:0]             req_valid,
  output logic [1:0]             req_ready,
  input  logic [1:0][ADDR_W-1:0] req_addr,
  input  logic [1:0][1:0]        req_oplen,
  input  logic [1:0][DATA_W-1:0] req_wdata,
  input  logic [1:0]             req_rw,
  output logic [1:0]             resp_valid,
  output logic [DATA_W-1:0]      resp_rdata,
  output logic [ADDR_W-1:0]      c_addr,
  output logic [1:0]             c_oplen,
  output logic [DATA_W-1:0]      c_wdata,
  output logic                   c_rw,
  output logic                   c_enable,
  output logic                   c_refresh,
  input  logic                   c_ready,
  input  logic                   c_done,
  input  logic [DATA_W-1:0]      c_rdata,
  output logic                   refresh_overrun
);

  arb_state_t state;
  sdram_req_t slot [2];
  logic [1:0] slot_full;
  logic [1:0] load;
  logic [1:0] clr;
  logic       owner;
  logic       rr;
  logic       win;
  logic       ref_pending;
  logic       ref_ack;

  assign req_ready = ~slot_full;
  assign load      = req_valid & req_ready;
  assign clr       = (state == ST_RESP) ? (owner ? 2'b10 : 2'b01) : 2'b00;
  assign ref_ack   = (state == ST_IDLE) && c_ready && ref_pending;

  sdram_refresh_timer #(
    .REFRESH_INTERVAL(REFRESH_INTERVAL)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .ack     (ref_ack),
    .pending (ref_pending),
    .overrun (refresh_overrun)
  );

  // NOTE: default assigned first so every path through the block drives win; no latch.
  always_comb begin
    win = 1'b0;
    if (slot_full == 2'b11)
      win = rr;
    else
      win = slot_full[1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      slot_full <= 2'b00;
    else
      for (int i = 0; i < 2; i++) begin
        if (load[i])
          slot_full[i] <= 1'b1;
        else if (clr[i])
          slot_full[i] <= 1'b0;
      end
  end

  // NOTE: payload storage has no reset; slot_full alone says whether it is meaningful.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++)
      if (load[i])
        slot[i] <= '{addr: req_addr[i], oplen: req_oplen[i],
                     wdata: req_wdata[i], rw: req_rw[i]};
  end

  // NOTE: strobes default low with non-blocking assignments; a later assignment in
  // the same cycle wins, which gives clean one-cycle pulses without ordering races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      owner      <= 1'b0;
      rr         <= 1'b0;
      c_enable   <= 1'b0;
      c_refresh  <= 1'b0;
      c_addr     <= '0;
      c_oplen    <= OPLEN_1;
      c_wdata    <= '0;
      c_rw       <= 1'b0;
      resp_valid <= 2'b00;
      resp_rdata <= '0;
    end else begin
      c_enable   <= 1'b0;
      c_refresh  <= 1'b0;
      resp_valid <= 2'b00;
      unique case (state)
        ST_IDLE: begin
          if (c_ready) begin
            if (ref_pending) begin
              c_refresh <= 1'b1;
              state     <= ST_REF;
            end else if (|slot_full) begin
              owner    <= win;
              rr       <= ~win;
              {c_addr, c_oplen, c_wdata, c_rw} <= slot[win];
              c_enable <= 1'b1;
              state    <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: state <= ST_WAIT;
        ST_WAIT: begin
          if (c_done) begin
            resp_valid <= owner ? 2'b10 : 2'b01;
            resp_rdata <= c_rw ? '0 : c_rdata;
            state      <= ST_RESP;
          end
        end
        ST_RESP:     state <= ST_IDLE;
        ST_REF:      state <= ST_WAIT_REF;
        ST_WAIT_REF: if (c_done) state <= ST_IDLE;
        default:     state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_req_arbiter.sv
// Directed bench: one instance at the default refresh interval for request
// behaviour, one at interval 8 for refresh timing, priority and overrun.
module tb_sdram_req_arbiter;
  import sdram_pkg::*;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [1:0]             req_valid;
  logic [1:0][ADDR_W-1:0] req_addr;
  logic [1:0][1:0]        req_oplen;
  logic [1:0][DATA_W-1:0] req_wdata;
  logic [1:0]             req_rw;
  logic [DATA_W-1:0]      c_rdata;

  logic [1:0]        req_ready, resp_valid;
  logic [DATA_W-1:0] resp_rdata, c_wdata;
  logic [ADDR_W-1:0] c_addr;
  logic [1:0]        c_oplen;
  logic              c_rw, c_enable, c_refresh, c_ready, c_done, refresh_overrun;

  logic [1:0]        req_ready_r, resp_valid_r;
  logic [DATA_W-1:0] resp_rdata_r, c_wdata_r;
  logic [ADDR_W-1:0] c_addr_r;
  logic [1:0]        c_oplen_r;
  logic              c_rw_r, c_enable_r, c_refresh_r, c_ready_r, refresh_overrun_r;
  logic              c_done_r = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  bit auto_r   = 1'b0;
  bit dly_r    = 1'b0;

  always #5 clk = ~clk;

  sdram_req_arbiter #(.REFRESH_INTERVAL(780)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_oplen(req_oplen), .req_wdata(req_wdata), .req_rw(req_rw),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .c_addr(c_addr), .c_oplen(c_oplen),
    .c_wdata(c_wdata), .c_rw(c_rw), .c_enable(c_enable), .c_refresh(c_refresh),
    .c_ready(c_ready), .c_done(c_done), .c_rdata(c_rdata), .refresh_overrun(refresh_overrun)
  );

  sdram_req_arbiter #(.REFRESH_INTERVAL(8)) dut_r (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready_r),
    .req_addr(req_addr), .req_oplen(req_oplen), .req_wdata(req_wdata), .req_rw(req_rw),
    .resp_valid(resp_valid_r), .resp_rdata(resp_rdata_r), .c_addr(c_addr_r),
    .c_oplen(c_oplen_r), .c_wdata(c_wdata_r), .c_rw(c_rw_r), .c_enable(c_enable_r),
    .c_refresh(c_refresh_r), .c_ready(c_ready_r), .c_done(c_done_r), .c_rdata(c_rdata),
    .refresh_overrun(refresh_overrun_r)
  );

  // Controller model for dut_r: completes every strobe one cycle later.
  always @(negedge clk) begin
    if (!auto_r) begin
      c_done_r = 1'b0;
      dly_r    = 1'b0;
    end else begin
      c_done_r = dly_r;
      dly_r    = c_enable_r | c_refresh_r;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench one cycle into reset release (cycle 0 after reset).
  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic wait_en(input bit use_r, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if ((use_r ? c_enable_r : c_enable) === 1'b1) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic do_grant(input int port, input logic [ADDR_W-1:0] exp_addr);
    bit ok;
    wait_en(1'b0, ok);
    check($sformatf("grant_p%0d_seen", port), 64'(ok), 64'd1);
    check($sformatf("grant_p%0d_addr", port), 64'(c_addr), 64'(exp_addr));
    step();
    c_done  = 1'b1;
    c_rdata = DATA_W'(exp_addr) ^ 32'h5A5A0000;
    step();
    c_done = 1'b0;
    check($sformatf("grant_p%0d_resp", port), 64'(resp_valid), (port == 0) ? 64'd1 : 64'd2);
    check($sformatf("grant_p%0d_rdata", port), 64'(resp_rdata),
          64'(DATA_W'(exp_addr) ^ 32'h5A5A0000));
    step();
  endtask

  initial begin
    bit ok;
    int gap, n_ref, n_en;

    rst_n     = 1'b0;
    req_valid = 2'b00;
    req_addr  = '0;
    req_oplen = '0;
    req_wdata = '0;
    req_rw    = 2'b00;
    c_rdata   = '0;
    c_ready   = 1'b1;
    c_done    = 1'b0;
    c_ready_r = 1'b0;
    step();
    step();

    check("rst_req_ready", 64'(req_ready), 64'd3);
    check("rst_c_enable", 64'(c_enable), 64'd0);
    check("rst_c_refresh", 64'(c_refresh), 64'd0);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_c_addr", 64'(c_addr), 64'd0);
    check("rst_overrun", 64'(refresh_overrun), 64'd0);
    rst_n = 1'b1;

    // Single P0 read: handshake at cycle N.
    req_valid    = 2'b01;
    req_addr[0]  = 25'h0000123;
    req_oplen[0] = OPLEN_4;
    req_rw[0]    = 1'b0;
    step();
    req_valid = 2'b00;
    check("rd_ready_low", 64'(req_ready), 64'd2);
    check("rd_en_n1", 64'(c_enable), 64'd0);
    step();
    check("rd_en_n2", 64'(c_enable), 64'd1);
    check("rd_addr", 64'(c_addr), 64'h123);
    check("rd_oplen", 64'(c_oplen), 64'(OPLEN_4));
    check("rd_rw", 64'(c_rw), 64'd0);
    step();
    check("rd_en_pulse", 64'(c_enable), 64'd0);
    step();
    step();
    c_done  = 1'b1;
    c_rdata = 32'hDEADBEEF;
    step();
    c_done = 1'b0;
    check("rd_resp", 64'(resp_valid), 64'd1);
    check("rd_rdata", 64'(resp_rdata), 64'hDEADBEEF);
    check("rd_ready_held", 64'(req_ready), 64'd2);
    step();
    check("rd_resp_pulse", 64'(resp_valid), 64'd0);
    check("rd_ready_back", 64'(req_ready), 64'd3);

    // Both ports together, four times: grants alternate from P0.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      req_valid   = 2'b11;
      req_addr[0] = ADDR_W'(32'h100 + k);
      req_addr[1] = ADDR_W'(32'h200 + k);
      req_rw      = 2'b00;
      step();
      req_valid = 2'b00;
      do_grant(0, ADDR_W'(32'h100 + k));
      do_grant(1, ADDR_W'(32'h200 + k));
    end

    // P1 write at the top address; controller fields must hold until c_done.
    req_valid    = 2'b10;
    req_addr[1]  = 25'h1FFFFFF;
    req_wdata[1] = 32'hA5A5A5A5;
    req_oplen[1] = OPLEN_8;
    req_rw[1]    = 1'b1;
    step();
    req_valid    = 2'b00;
    req_addr[1]  = '0;
    req_wdata[1] = '0;
    wait_en(1'b0, ok);
    check("wr_seen", 64'(ok), 64'd1);
    check("wr_rw", 64'(c_rw), 64'd1);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("wr_addr_hold%0d", i), 64'(c_addr), 64'h1FFFFFF);
      check($sformatf("wr_data_hold%0d", i), 64'(c_wdata), 64'hA5A5A5A5);
      step();
    end
    c_done  = 1'b1;
    c_rdata = 32'h12345678;
    step();
    c_done = 1'b0;
    check("wr_resp", 64'(resp_valid), 64'd2);
    check("wr_rdata_zero", 64'(resp_rdata), 64'd0);
    step();
    step();
    c_done = 1'b1;
    step();
    c_done = 1'b0;
    step();
    check("idle_done_ignored", 64'(resp_valid), 64'd0);

    // Reset while waiting on the controller.
    req_valid   = 2'b01;
    req_addr[0] = 25'h0ABCDEF;
    req_rw[0]   = 1'b0;
    step();
    req_valid = 2'b00;
    wait_en(1'b0, ok);
    check("rstw_seen", 64'(ok), 64'd1);
    step();
    rst_n = 1'b0;
    #1;
    check("rstw_addr", 64'(c_addr), 64'd0);
    check("rstw_ready", 64'(req_ready), 64'd3);
    check("rstw_enable", 64'(c_enable), 64'd0);
    check("rstw_resp", 64'(resp_valid), 64'd0);
    step();
    rst_n  = 1'b1;
    c_done = 1'b1;
    step();
    c_done = 1'b0;
    check("rstw_no_resp", 64'(resp_valid), 64'd0);
    step();
    check("rstw_no_resp2", 64'(resp_valid), 64'd0);

    // Interval 8: pending refresh beats a waiting request once c_ready rises.
    do_reset();
    auto_r      = 1'b1;
    c_ready_r   = 1'b0;
    req_valid   = 2'b01;
    req_addr[0] = 25'h0000777;
    step();
    req_valid = 2'b00;
    for (int i = 0; i < 8; i++) step();
    check("pre_blocked", 64'(c_enable_r), 64'd0);
    c_ready_r = 1'b1;
    step();
    check("pre_refresh", 64'(c_refresh_r), 64'd1);
    check("pre_no_enable", 64'(c_enable_r), 64'd0);
    wait_en(1'b1, ok);
    check("pre_req_after", 64'(ok), 64'd1);
    check("pre_req_addr", 64'(c_addr_r), 64'h777);

    // Saturating traffic: refresh keeps pace, never overruns.
    do_reset();
    req_valid = 2'b11;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (c_refresh_r === 1'b1) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    check("sat_first_ref", 64'(ok), 64'd1);
    gap   = 0;
    n_ref = 0;
    n_en  = 0;
    for (int i = 0; i < 80; i++) begin
      step();
      gap++;
      if (c_enable_r === 1'b1) n_en++;
      if (c_refresh_r === 1'b1) begin
        check("sat_gap", 64'(gap >= 5 && gap <= 11), 64'd1);
        n_ref++;
        gap = 0;
      end
    end
    req_valid = 2'b00;
    check("sat_ref_count", 64'(n_ref >= 9 && n_ref <= 11), 64'd1);
    check("sat_traffic", 64'(n_en >= 8), 64'd1);
    check("sat_no_overrun", 64'(refresh_overrun_r), 64'd0);

    // Controller stalled: second expiry with refresh still pending sets overrun.
    auto_r    = 1'b0;
    c_ready_r = 1'b0;
    do_reset();
    for (int i = 0; i < 15; i++) step();
    check("ovr_not_yet", 64'(refresh_overrun_r), 64'd0);
    step();
    check("ovr_set", 64'(refresh_overrun_r), 64'd1);
    for (int i = 0; i < 4; i++) step();
    auto_r    = 1'b1;
    c_ready_r = 1'b1;
    for (int i = 0; i < 5; i++) step();
    check("ovr_sticky", 64'(refresh_overrun_r), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
